// File: rtl/mod_n_up_counter_pkg.sv
// Shared types, helpers and parameter-legality check for the modulo-N counter family.
// Package name counter_pkg is kept so future counters and the Gray FIFO can share it.
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Elaboration-time guard: MODULO must lie in 2..2**W, W within the helper width.
`define COUNTER_CHECK_PARAMS(W, M) \
  if ((W) < 1 || (W) > counter_pkg::GRAY_MAX_W || (M) < 2 || (M) > (64'd1 << (W))) begin : g_param_err \
    $error("mod_n_up_counter: illegal WIDTH/MODULO combination"); \
  end

package counter_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC
  } count_op_e;

  function automatic logic [GRAY_MAX_W-1:0] to_gray(input logic [GRAY_MAX_W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic int unsigned max_count(input int unsigned modulo);
    return modulo - 1;
  endfunction

endpackage

`endif

// File: rtl/mod_n_up_counter_if.sv
// Control and status bundle of one modulo-N counter stage.
interface mod_n_up_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_gray;
  logic             tc;
  logic             wrap;
  logic             ovf;
  logic             load_err;

  modport master (
    output en, clr, load, load_val, ovf_clr,
    input  q, q_gray, tc, wrap, ovf, load_err
  );

  modport slave (
    input  en, clr, load, load_val, ovf_clr,
    output q, q_gray, tc, wrap, ovf, load_err
  );
endinterface

// File: rtl/mod_n_up_counter_gray_encode_reg.sv
// WIDTH-bit register holding the Gray code of its binary input; async active-low reset.
module gray_encode_reg
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [GRAY_MAX_W-1:0] gray_wide;

  assign gray_wide = to_gray(GRAY_MAX_W'(d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= gray_wide[WIDTH-1:0];
  end
endmodule

// File: rtl/mod_n_up_counter.sv
// Loadable modulo-N up counter with terminal count, wrap, sticky overflow and Gray copy.
module mod_n_up_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned MODULO = 8
) (
  input logic                clk,
  input logic                rst_n,
  mod_n_up_counter_if.slave  bus
);
  `COUNTER_CHECK_PARAMS(WIDTH, MODULO)

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULO));
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH:0]   inc_w;
  logic             at_max;
  logic             load_ok;
  logic             next_wrap;
  logic             next_load_err;
  logic             wrap_r;
  logic             ovf_r;
  logic             load_err_r;
  count_op_e        op;

  assign at_max  = (q == MAX_Q);
  assign load_ok = ({1'b0, bus.load_val} < MOD_W);
  assign inc_w   = {1'b0, q} + (WIDTH+1)'(1);

  always_comb begin
    op = OP_HOLD;
    if (bus.clr)       op = OP_CLR;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = OP_INC;
  end

  // q < MODULO always holds, so the wrap test alone keeps the increment in range
  always_comb begin
    next_q        = q;
    next_wrap     = 1'b0;
    next_load_err = 1'b0;
    case (op)
      OP_CLR:  next_q = '0;
      OP_LOAD: begin
        if (load_ok) next_q        = bus.load_val;
        else         next_load_err = 1'b1;
      end
      OP_INC: begin
        if (at_max) begin
          next_q    = '0;
          next_wrap = 1'b1;
        end else begin
          next_q = inc_w[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      wrap_r     <= 1'b0;
      ovf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q          <= next_q;
      wrap_r     <= next_wrap;
      load_err_r <= next_load_err;
      if (next_wrap)        ovf_r <= 1'b1;
      else if (bus.ovf_clr) ovf_r <= 1'b0;
    end
  end

  gray_encode_reg #(.WIDTH(WIDTH)) u_gray (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (next_q),
    .q     (bus.q_gray)
  );

  assign bus.q        = q;
  assign bus.wrap     = wrap_r;
  assign bus.ovf      = ovf_r;
  assign bus.load_err = load_err_r;
  assign bus.tc       = bus.en & ~bus.clr & ~bus.load & at_max;
endmodule

// File: doc/mod_n_up_counter.md
Name: mod_n_up_counter

Overview:
- Synchronous, loadable, modulo-N up counter; the counting-up counterpart of the team's 3-bit down counter.
- Serves as the general-purpose event and tick counter for timers and prescalers.
- Provides terminal-count, wrap and sticky-overflow flags plus a Gray-coded copy of the count for clock-domain crossing.
- Instances cascade by wiring the lower stage's tc into the next stage's en.

Parameters:
- WIDTH, 3, counter width in bits.
- MODULO, 8, count range 0..MODULO-1. Legal range 2..2**WIDTH; out of range is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  count enable; increment when high.
- clr  input  1  synchronous clear of count.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- ovf_clr  input  1  clears sticky ovf.
- q  output  WIDTH  current count, registered.
- q_gray  output  WIDTH  Gray code of q, registered, same cycle as q.
- tc  output  1  terminal count, combinational: en & ~clr & ~load & (q==MODULO-1).
- wrap  output  1  one-cycle registered pulse after a wrap from MODULO-1 to 0.
- ovf  output  1  sticky wrap flag.
- load_err  output  1  one-cycle registered pulse for a rejected load.

Behaviour:
- Reset: on rst_n low, immediately and independent of clk, q=0, q_gray=0, wrap=0, ovf=0, load_err=0. Reset mid-count aborts the count; counting resumes from 0 on the first edge after rst_n goes high.
- Priority per edge: clr > load > en. Otherwise q holds.
- clr:
  - q<=0.
  - wrap<=0 and load_err<=0.
  - ovf unaffected.
- load (with clr low):
  - load_val < MODULO: q<=load_val, load_err<=0.
  - load_val >= MODULO: q holds, load_err<=1 for one cycle.
  - wrap<=0.
- en (with clr and load low):
  - q==MODULO-1: q<=0, wrap<=1, ovf<=1.
  - otherwise: q<=q+1, wrap<=0.
- Idle: wrap and load_err return to 0 on any edge where their set condition is absent.
- ovf: set only by a wrap; cleared by ovf_clr. If set and clear occur on the same edge, set wins.
- q_gray: registered as next_q ^ (next_q>>1), so it always equals the Gray code of q. For MODULO not a power of two, the wrap step is not single-bit.
- Latency:
  - q, wrap, load_err: 1 cycle from the qualifying edge.
  - tc: combinational, 0 cycles.
- Arithmetic: q never holds a value >= MODULO. Increment is computed WIDTH+1 wide before the compare, so no unintended natural overflow.
- Cascade: the next stage samples en=tc of this stage. This gives a synchronous carry with no ripple clocking.

Decomposition:
- Package counter_pkg holds:
  - function to_gray(WIDTH-bit value);
  - function max_count(MODULO) returning MODULO-1;
  - the parameter-legality check macro.
- One sub-module: gray_encode_reg, a WIDTH-bit register that stores to_gray(next_q) under rst_n. It is reusable by the future Gray-pointer FIFO.
- Next-state selection and flags stay in the top module.

Test Plan:
1. Reset and free run (WIDTH=3, MODULO=8): rst_n=0 for 12 ns, then en=1 for 10 cycles -> q = 0,1,...,7,0,1. wrap=1 exactly one cycle after the 7->0 step. ovf=1 from then on. tc high while q==7. q_gray follows 000,001,011,010,110,111,101,100.
2. Modulo 6 (MODULO=6): en=1 for 7 cycles -> q = 0..5,0. tc=1 only at q=5. q never reaches 6 or 7.
3. Load: load=1, load_val=5 -> q=5 next cycle, load_err=0. Then load_val=7 with MODULO=6 -> q holds 5, load_err=1 for one cycle.
4. Priority: clr=1, load=1, load_val=3, en=1 at q=4 -> q=0. Then load=1, en=1, load_val=2 -> q=2, no increment.
5. Sticky flag: hold ovf=1, then assert ovf_clr on the same edge as a 7->0 wrap -> ovf stays 1. Assert ovf_clr alone -> ovf=0 next cycle.
6. Async reset mid-count: at q=5, drop rst_n between edges -> q=0 and all flags 0 immediately, before the next edge. Release rst_n -> q=1 after the first enabled edge.
